st7066u_bus_writer: RTL

ST7066U_BUS_WRITER -- requirements
Module: st7066u_bus_writer

---
 rtl/st7066u_bus_writer_pkg.sv | 24 ++
 rtl/st7066u_bus_writer_if.sv | 14 +
 rtl/st7066u_bus_writer_phase_timer.sv | 18 +
 rtl/st7066u_bus_writer.sv | 89 ++++++++
 4 files changed

// File: rtl/st7066u_bus_writer_pkg.sv
// st7066u_pkg: FSM state codes, default ST7066U timing and the long-execution command range.
package st7066u_pkg;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_EXEC  = 3'd4;
   localparam logic [2:0] ST_PWRUP = 3'd5;
   localparam int DEF_T_SETUP_CYC     = 4;
   localparam int DEF_T_PULSE_CYC     = 25;
   localparam int DEF_T_HOLD_CYC      = 2;
   localparam int DEF_T_EXEC_CYC      = 4000;
   localparam int DEF_T_EXEC_LONG_CYC = 160000;
   localparam int DEF_T_POWERUP_CYC   = 4000000;
   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
   localparam logic [7:0] LONG_CMD_LO = 8'h01;
   localparam logic [7:0] LONG_CMD_HI = 8'h03;
   function automatic logic is_long(input logic rs, input logic [7:0] d);
      return !rs && d >= LONG_CMD_LO && d <= LONG_CMD_HI;
   endfunction
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/st7066u_bus_writer_if.sv
// st7066u_bus_writer_if: write-request handshake plus ST7066U parallel bus pins.
interface st7066u_bus_writer_if;
   logic       i_start;
   logic       i_rs;
   logic [7:0] i_d;
   logic       o_ready;
   logic       o_done;
   logic       o_lcd_rs;
   logic       o_lcd_rw;
   logic       o_lcd_e;
   logic [7:0] o_lcd_db;
   modport master (output i_start, i_rs, i_d, input o_ready, o_done, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db);
   modport slave  (input i_start, i_rs, i_d, output o_ready, o_done, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db);
endinterface

// File: rtl/st7066u_bus_writer_phase_timer.sv
// st7066u_phase_timer: loadable down-counter; load N-1, expired while the count sits at 0.
module st7066u_phase_timer #(
   parameter int W       = 8,
   parameter int RST_VAL = 0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_expired
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = i_load ? i_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
   always_ff @(posedge i_clk)
      if (i_rst) cnt_q <= W'(RST_VAL);
      else       cnt_q <= cnt_d;
   assign o_expired = cnt_q == '0;
endmodule

// File: rtl/st7066u_bus_writer.sv
// st7066u_bus_writer: timed single-byte write to an ST7066U LCD with post-write execution wait.
// Define ST7066U_POWERUP_WAIT_EN to hold off the first write for T_POWERUP_CYC cycles after reset.
module st7066u_bus_writer
   import st7066u_pkg::*;
#(
   parameter int T_SETUP_CYC     = DEF_T_SETUP_CYC,
   parameter int T_PULSE_CYC     = DEF_T_PULSE_CYC,
   parameter int T_HOLD_CYC      = DEF_T_HOLD_CYC,
   parameter int T_EXEC_CYC      = DEF_T_EXEC_CYC,
   parameter int T_EXEC_LONG_CYC = DEF_T_EXEC_LONG_CYC,
   parameter int T_POWERUP_CYC   = DEF_T_POWERUP_CYC
) (
   input logic               i_clk,
   input logic               i_rst,
   st7066u_bus_writer_if.slave bus
);
`ifdef ST7066U_POWERUP_WAIT_EN
   localparam logic [2:0] RST_STATE = ST_PWRUP;
   localparam int         RST_CNT   = T_POWERUP_CYC - 1;
   localparam logic       RST_READY = 1'b0;
   localparam int         MAX_PU    = T_POWERUP_CYC;
`else
   localparam logic [2:0] RST_STATE = ST_IDLE;
   localparam int         RST_CNT   = 0;
   localparam logic       RST_READY = 1'b1;
   localparam int         MAX_PU    = 1;
`endif
   localparam int MAXV = max2(max2(max2(T_SETUP_CYC, T_PULSE_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)),
                              max2(T_EXEC_LONG_CYC, MAX_PU));
   localparam int W = $clog2(MAXV + 1);
   logic [2:0]   state_q, state_d;
   logic         rs_q, rs_d, e_q, e_d, ready_q, ready_d, done_q, done_d;
   logic [7:0]   db_q, db_d;
   logic         load, expired, accept;
   logic [W-1:0] load_val;
   st7066u_phase_timer #(.W(W), .RST_VAL(RST_CNT)) u_timer (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(load), .i_val(load_val), .o_expired(expired)
   );
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = '0;
      accept   = state_q == ST_IDLE && bus.i_start;
      if (accept) begin
         state_d  = ST_SETUP;
         load     = 1'b1;
         load_val = W'(T_SETUP_CYC - 1);
      end else if (expired) begin
         case (state_q)
            ST_SETUP: begin state_d = ST_PULSE; load = 1'b1; load_val = W'(T_PULSE_CYC - 1); end
            ST_PULSE: begin state_d = ST_HOLD;  load = 1'b1; load_val = W'(T_HOLD_CYC - 1); end
            ST_HOLD: begin
               state_d  = ST_EXEC;
               load     = 1'b1;
               load_val = is_long(rs_q, db_q) ? W'(T_EXEC_LONG_CYC - 1) : W'(T_EXEC_CYC - 1);
            end
            ST_EXEC, ST_PWRUP: state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      end
      rs_d    = accept ? bus.i_rs : rs_q;
      db_d    = accept ? bus.i_d : db_q;
      e_d     = state_d == ST_PULSE;
      ready_d = state_d == ST_IDLE;
      done_d  = state_q == ST_EXEC && expired;
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state_q <= RST_STATE;
         rs_q    <= 1'b0;
         db_q    <= 8'h00;
         e_q     <= 1'b0;
         ready_q <= RST_READY;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         db_q    <= db_d;
         e_q     <= e_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   assign bus.o_ready  = ready_q;
   assign bus.o_done   = done_q;
   assign bus.o_lcd_rs = rs_q;
   assign bus.o_lcd_rw = 1'b0;
   assign bus.o_lcd_e  = e_q;
   assign bus.o_lcd_db = db_q;
endmodule
